// File: rtl/mux2_arb_16b.sv
`default_nettype none
// ============================================================================
// Module   : mux2_arb_16b
// Brief    : Round-robin, burst-bounded arbiter driving a 16-bit 2:1 mux into
//            a one-entry valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_arb_16b #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic        sel,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_src,
    input  logic        out_ready
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [7:0] CNT_SAT   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q;
    logic        sel_q;
    logic        out_valid_q;
    logic [15:0] out_data_q;
    logic        out_src_q;

    logic        cap_en;
    logic        grant;
    logic        grant_src;
    logic [7:0]  cnt_inc;

    assign cap_en  = !out_valid_q || out_ready;
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 8'd1;

    // rst also gates the grant so acks drop the moment reset is asserted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        grant_src = sel_q;
        if (cap_en && !rst) begin
            case (state_q)
                OWN_A: begin
                    if (req_a && ((cnt_q < BURST_LIM) || !req_b)) begin
                        grant     = 1'b1;
                        grant_src = 1'b0;
                        cnt_d     = cnt_inc;
                    end else if (req_b) begin
                        grant     = 1'b1;
                        grant_src = 1'b1;
                        state_d   = OWN_B;
                        cnt_d     = 8'd1;
                    end else begin
                        state_d   = IDLE;
                        cnt_d     = 8'd0;
                    end
                end
                OWN_B: begin
                    if (req_b && ((cnt_q < BURST_LIM) || !req_a)) begin
                        grant     = 1'b1;
                        grant_src = 1'b1;
                        cnt_d     = cnt_inc;
                    end else if (req_a) begin
                        grant     = 1'b1;
                        grant_src = 1'b0;
                        state_d   = OWN_A;
                        cnt_d     = 8'd1;
                    end else begin
                        state_d   = IDLE;
                        cnt_d     = 8'd0;
                    end
                end
                default: begin
                    if (req_a || req_b) begin
                        grant     = 1'b1;
                        // On a tie the requester not granted last wins.
                        grant_src = (req_a && req_b) ? !last_q : req_b;
                        state_d   = grant_src ? OWN_B : OWN_A;
                        cnt_d     = 8'd1;
                    end else begin
                        state_d   = IDLE;
                        cnt_d     = 8'd0;
                    end
                end
            endcase
        end
    end

    assign ack_a     = grant && !grant_src;
    assign ack_b     = grant && grant_src;
    assign sel       = grant ? grant_src : sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel;
            if (grant) begin
                last_q <= grant_src;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_src_q   <= 1'b0;
        end else if (grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_src ? data_b : data_a;
            out_src_q   <= grant_src;
        end else if (cap_en) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux2_arb_16b.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_arb_16b
// Brief    : Directed, table-driven self-checking bench for mux2_arb_16b.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_arb_16b;

    logic        clk;
    logic        rst;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        ack_a;
    logic        ack_b;
    logic        sel;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_src;
    logic        out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    mux2_arb_16b #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ra;
        logic [15:0] da;
        logic        rb;
        logic [15:0] db;
        logic        rdy;
        logic        aa;
        logic        ab;
        logic        sel;
        logic        ov;
        logic [15:0] od;
        logic        os;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic ra, input logic [15:0] da,
                                input logic rb, input logic [15:0] db, input logic rdy,
                                input logic aa, input logic ab, input logic s,
                                input logic ov, input logic [15:0] od, input logic os);
        vec_t v;
        v.rst = r;  v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.rdy = rdy;
        v.aa = aa;  v.ab = ab; v.sel = s; v.ov = ov; v.od = od; v.os = os;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".ack_a"},     16'(ack_a),     16'(v.aa));
        chk({tag, ".ack_b"},     16'(ack_b),     16'(v.ab));
        chk({tag, ".sel"},       16'(sel),       16'(v.sel));
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(v.ov));
        chk({tag, ".out_data"},  out_data,       v.od);
        chk({tag, ".out_src"},   16'(out_src),   16'(v.os));
    endtask

    // Drive one cycle's inputs just after the edge, check before the next one.
    task automatic run_row(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        rst       = v.rst;
        req_a     = v.ra;
        data_a    = v.da;
        req_b     = v.rb;
        data_b    = v.db;
        out_ready = v.rdy;
        @(negedge clk);
        chk_all(tag, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [15:0] DA = 16'h0F0F;
    localparam logic [15:0] DB = 16'hF0F0;

    initial begin
        vec_t mid;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        data_a = 16'h0; data_b = 16'h0; out_ready = 1'b0;

        // Reset, idle, fair sharing, owner drop and drain.
        tbl.push_back(mk(1,0,16'h0,0,16'h0,0, 0,0,0,0,16'h0000,0));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1, 0,0,0,0,16'h0000,0));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1, 0,0,0,0,16'h0000,0));
        tbl.push_back(mk(0,1,DA,1,DB,1, 1,0,0,0,16'h0000,0));
        tbl.push_back(mk(0,1,DA,1,DB,1, 1,0,0,1,DA,0));
        tbl.push_back(mk(0,1,DA,1,DB,1, 1,0,0,1,DA,0));
        tbl.push_back(mk(0,1,DA,1,DB,1, 1,0,0,1,DA,0));
        tbl.push_back(mk(0,1,DA,1,DB,1, 0,1,1,1,DA,0));
        tbl.push_back(mk(0,1,DA,1,DB,1, 0,1,1,1,DB,1));
        tbl.push_back(mk(0,1,DA,1,DB,1, 0,1,1,1,DB,1));
        tbl.push_back(mk(0,1,DA,1,DB,1, 0,1,1,1,DB,1));
        tbl.push_back(mk(0,1,DA,1,DB,1, 1,0,0,1,DB,1));
        tbl.push_back(mk(0,1,DA,1,DB,1, 1,0,0,1,DA,0));
        tbl.push_back(mk(0,0,DA,1,DB,1, 0,1,1,1,DA,0));
        tbl.push_back(mk(0,0,DA,1,DB,1, 0,1,1,1,DB,1));
        tbl.push_back(mk(0,1,DA,1,DB,1, 0,1,1,1,DB,1));
        tbl.push_back(mk(0,1,DA,1,DB,1, 0,1,1,1,DB,1));
        tbl.push_back(mk(0,0,DA,1,DB,1, 0,1,1,1,DB,1));
        tbl.push_back(mk(0,0,DA,0,DB,1, 0,0,1,1,DB,1));
        tbl.push_back(mk(0,0,DA,0,DB,1, 0,0,1,0,DB,1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_row($sformatf("row%0d", i), tbl[i]);
        end

        // Backpressure on a B stream: held word, no ack, nothing lost or repeated.
        run_row("bp0", mk(0,0,16'h0,1,16'h1234,1, 0,1,1,0,DB,1));
        run_row("bp1", mk(0,0,16'h0,1,16'h1235,0, 0,0,1,1,16'h1234,1));
        run_row("bp2", mk(0,0,16'h0,1,16'h1235,0, 0,0,1,1,16'h1234,1));
        run_row("bp3", mk(0,0,16'h0,1,16'h1235,0, 0,0,1,1,16'h1234,1));
        run_row("bp4", mk(0,0,16'h0,1,16'h1235,1, 0,1,1,1,16'h1234,1));
        run_row("bp5", mk(0,0,16'h0,1,16'h1236,1, 0,1,1,1,16'h1235,1));
        run_row("bp6", mk(0,0,16'h0,0,16'h1236,1, 0,0,1,1,16'h1236,1));
        run_row("bp7", mk(0,0,16'h0,0,16'h1236,1, 0,0,1,0,16'h1236,1));

        // Asynchronous reset between edges while a word is stalled.
        run_row("rs0", mk(0,0,16'h0,1,16'hABCD,1, 0,1,1,0,16'h1236,1));
        run_row("rs1", mk(0,0,16'h0,1,16'hABCE,0, 0,0,1,1,16'hABCD,1));
        #2;
        rst = 1'b1;
        #1;
        mid = mk(1,0,16'h0,1,16'hABCE,0, 0,0,0,0,16'h0000,0);
        chk_all("rs_async", mid);
        run_row("rs2", mk(1,0,16'h0,1,16'hABCE,1, 0,0,0,0,16'h0000,0));
        run_row("rs3", mk(0,0,16'h0,0,16'h0,1, 0,0,0,0,16'h0000,0));
        run_row("rs4", mk(0,1,16'h5A5A,0,16'h0,1, 1,0,0,0,16'h0000,0));
        run_row("rs5", mk(0,0,16'h5A5A,0,16'h0,1, 0,0,0,1,16'h5A5A,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2_arb_16b.md
Name: mux2_arb_16b

Overview:
- Sequencing controller and round-robin arbiter that shares the 16-bit 2:1 mux datapath between two requesters (A, B).
- Drives the mux select, captures the selected word into a one-entry output register, and hands it downstream with a valid/ready handshake.
- Bounds each requester's burst so neither starves the other.
- Sits between two 16-bit producers and a single 16-bit consumer.

Parameters:
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is requesting. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_a  input  1  requester A has a word on data_a.
- data_a  input  16  requester A word (mux input A).
- req_b  input  1  requester B has a word on data_b.
- data_b  input  16  requester B word (mux input B).
- ack_a  output  1  A's word captured this cycle (combinational, single-cycle).
- ack_b  output  1  B's word captured this cycle (combinational, single-cycle).
- sel  output  1  mux select (0 = A, 1 = B); drives the 2:1 mux S.
- out_valid  output  1  output register holds a word.
- out_data  output  16  registered output word.
- out_src  output  1  source of out_data (0 = A, 1 = B).
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Behaviour:
- Reset (asynchronous, rst = 1):
  - out_valid = 0, out_data = 16'h0000, out_src = 0, sel = 0, ack_a = ack_b = 0.
  - state = IDLE, burst count cnt (8-bit) = 0, last-granted pointer = B, so A wins the first tie.
- Capture enable: cap_en = !out_valid || out_ready. The output register can take a new word in the same cycle the old one drains.
- States:
  - IDLE: no owner.
  - OWN_A, OWN_B: current owner.
- Grant decision (combinational, only when cap_en = 1):
  - Owner X with req_X = 1 and (cnt < MAX_BURST or the other is not requesting): grant X; cnt <= cnt + 1, saturating at 255.
  - Otherwise, if the other requester Y has req_Y = 1: grant Y; state <= OWN_Y; cnt <= 1.
  - IDLE, both requesting: grant the requester that is not last-granted.
  - IDLE, one requesting: grant that requester; cnt <= 1.
  - No requests: no grant; state <= IDLE; cnt <= 0.
- On every grant to g:
  - sel = g in the same cycle; ack_g = 1 in the same cycle.
  - Next edge: out_data <= selected data, out_src <= g, out_valid <= 1, last-granted <= g.
- On cap_en = 1 with no grant: out_valid <= 0.
- Stall (out_valid = 1, out_ready = 0):
  - No ack, no grant.
  - state, cnt, sel, out_data and out_src frozen; out_valid stays 1.
- sel holds its last value whenever there is no grant.
- Throughput: one word per cycle when out_ready is held high. Latency from ack to out_valid is 1 cycle.
- A requester dropping req mid-burst releases ownership immediately (rule 2 or the IDLE rule applies).
- rst asserted mid-burst or mid-stall discards any held word; no ack follows until after deassertion.
- Requesters must hold data stable while req = 1 and ack = 0.
- req_a = req_b = 1 and A owns with cnt == MAX_BURST: B is granted. B then runs up to MAX_BURST, then A.

Test Plan:
- Reset: assert rst asynchronously between edges -> all outputs 0 immediately; after release with req_a = 0 and req_b = 0, out_valid stays 0.
- Single requester A: req_a = 1, data_a = 16'h00FF, out_ready = 1 for 6 cycles -> ack_a high every cycle, sel = 0, out_data = 16'h00FF, out_src = 0, out_valid = 1 from cycle 2.
- Fair sharing with MAX_BURST = 4: req_a = req_b = 1, data_a = 16'h0F0F, data_b = 16'hF0F0, out_ready = 1 -> out_src sequence A,A,A,A,B,B,B,B,A…; A granted first; never 5 in a row.
- Backpressure: during the B stream (data_b = 16'h1234), drop out_ready for 3 cycles -> out_valid = 1, out_data = 16'h1234 held, ack_b = 0, sel frozen; out_ready = 1 -> streaming resumes with no word lost or duplicated.
- Owner drop: A owns with cnt = 2 and req_b = 1; deassert req_a -> B granted next cycle, cnt restarts at 1.
- Drain: both requests drop while out_valid = 1 and out_ready = 1 -> out_valid = 0 next cycle; state returns to IDLE; sel keeps its last value.
